imem_load_ctrl: RTL and testbench
=================================

Name: imem_load_ctrl

Overview:
- Boot/debug loader controller that sequences writes into the 64-word instruction memory and arbitrates its single address port between CPU fetch and the loader.
- Accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them to consecutive word addresses starting at 0.
- Holds the CPU in stall while a load is in progress, then releases it with a one-cycle done pulse.

Parameters:
- DEPTH, 64, number of 32-bit words in instruction memory.
- ADDR_W, 6, word-address width; must equal clog2(DEPTH).

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- load_start  input  1  begin a load; sampled only in IDLE
- load_valid  input  1  load_data is valid this cycle
- load_data  input  32  instruction word to write
- load_last  input  1  qualifies the final word of the stream (meaningful only with load_valid)
- load_ready  output  1  controller accepts a word this cycle
- cpu_pc  input  32  CPU fetch address (byte address)
- imem_addr  output  32  byte address driven to the IMEM pc port
- imem_we  output  1  IMEM write enable
- imem_wdata  output  32  IMEM write data
- cpu_stall  output  1  freeze CPU PC/pipeline
- load_done  output  1  one-cycle pulse on successful completion
- load_err  output  1  sticky error flag; cleared by the next accepted load_start
- load_count  output  ADDR_W+1  number of words written by the current/last load

Behaviour:
- Reset values: state=IDLE, wr_ptr=0, load_count=0, load_err=0, load_done=0, cpu_stall=0, load_ready=0, imem_we=0.
- Reset mid-load: return to IDLE immediately, with all values as above; partially written words stay in IMEM.
- States: IDLE, LOAD, DONE (plus CHECK when the optional feature is enabled).
- IDLE:
  - imem_addr=cpu_pc, imem_we=0, cpu_stall=0, load_ready=0.
  - On load_start: clear wr_ptr, load_count and load_err; go to LOAD.
- LOAD:
  - cpu_stall=1, load_ready=1, imem_addr={wr_ptr, 2'b00} zero-extended to 32 bits.
  - Outputs are combinational: imem_we=load_valid, imem_wdata=load_data.
  - Word transfer occurs when valid&ready; IMEM captures it on the same clock edge; wr_ptr and load_count increment.
  - load_last with the transfer: go to DONE.
  - Overflow: a transfer at wr_ptr==DEPTH-1 without load_last still writes the word, sets load_err=1, goes to IDLE (no load_done), and wr_ptr does not wrap.
  - load_start while in LOAD is ignored.
  - load_valid=0: hold with no write (stalls of any length are legal).
- DONE: exactly one cycle; load_done=1, cpu_stall=1, load_ready=0, imem_we=0; next state IDLE.
- CPU resumes fetch on the cycle after DONE; the controller does not touch the CPU PC (the CPU owns its reset/redirect).
- Latency: one word per cycle max; an N-word load occupies N+2 cycles minimum (LOAD entry plus DONE).
- Addressing: byte address = word index * 4; bits [1:0] always 0 while loading.
- Simultaneous reset and load_start: reset wins.

Optional Feature:
- Macro: IMEM_LOAD_CHECKSUM_EN.
- Enabled:
  - The controller keeps a 32-bit running sum (modulo 2^32) of the words accepted since load_start.
  - The word carrying load_last moves the FSM to CHECK instead of DONE.
  - CHECK: load_ready=1, imem_we=0, cpu_stall=1. The next accepted word is the expected checksum and is not written to IMEM.
  - Match: go to DONE. Mismatch: set load_err=1 and go to IDLE without load_done.
- Disabled: no sum register and no CHECK state; load_last goes straight to DONE.

Decomposition:
- Shared package imem_pkg:
  - IMEM_DEPTH=64 and IMEM_ADDR_W=6 constants.
  - typedef enum logic [1:0] {LD_IDLE, LD_LOAD, LD_DONE, LD_CHECK} ld_state_t.
- No sub-module: the FSM, pointer and output mux live in one file. The IMEM itself is instantiated by the parent alongside this block.

Test Plan:
- Idle passthrough: load_start=0, cpu_pc=0x0000001C -> imem_addr=0x1C, imem_we=0, cpu_stall=0, load_ready=0.
- Basic load: load_start, then 3 back-to-back words 0x00500113, 0x00C00193, 0xFF718393 (last on the 3rd) -> writes at addresses 0x0/0x4/0x8, load_count=3, load_done pulses once, cpu_stall drops the following cycle.
- Gapped handshake: same 3 words with load_valid low for 2 cycles between words -> no imem_we during gaps, identical IMEM contents, load_count=3.
- Overflow: 65 words with no load_last -> 64 writes ending at 0xFC, load_err=1 after word 64, no load_done, return to IDLE; 65th word not accepted (load_ready=0).
- Reset mid-load: reset asserted after 2 of 5 words -> next cycle state IDLE, cpu_stall=0, load_count=0, load_err=0.
- Checksum (macro on): words 1, 2, 3 (last) then checksum 6 -> load_done=1. Repeat with checksum 7 -> load_err=1, no load_done.

Source files
------------

// File: rtl/imem_pkg.sv
// imem_pkg: shared constants and types for the instruction-memory loader.
//   IMEM_DEPTH  - number of 32-bit words in the instruction memory
//   IMEM_ADDR_W - word-address width (clog2 of IMEM_DEPTH)
//   ld_state_t  - loader FSM state encoding
package imem_pkg;

  localparam int IMEM_DEPTH  = 64;
  localparam int IMEM_ADDR_W = 6;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_LOAD,
    LD_DONE,
    LD_CHECK
  } ld_state_t;

endpackage

// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: boot/debug loader for the 64-word instruction memory.
// Streams 32-bit words over a valid/ready handshake into consecutive word
// addresses starting at 0. It shares the IMEM address port with CPU fetch and
// stalls the CPU while a load is in progress.
//
// Ports:
//   clk, reset       clock; synchronous active-high reset
//   load_start       begin a load (sampled only in IDLE)
//   load_valid/data  word stream; load_last marks the final word
//   load_ready       a word is accepted this cycle when valid & ready
//   cpu_pc           CPU fetch byte address, passed through when idle
//   imem_addr/we/wdata  IMEM port (byte address, write enable, write data)
//   cpu_stall        freeze the CPU while loading
//   load_done        one-cycle pulse on successful completion
//   load_err         sticky error (overflow / checksum mismatch)
//   load_count       words written by the current/last load
//
// Optional build macro: IMEM_LOAD_CHECKSUM_EN
//   When defined, the word after load_last is a 32-bit modulo-2^32 sum of the
//   loaded words. It is checked in a CHECK state and is not written to IMEM.
module imem_load_ctrl
  import imem_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic [31:0]       cpu_pc,
  output logic [31:0]       imem_addr,
  output logic              imem_we,
  output logic [31:0]       imem_wdata,
  output logic              cpu_stall,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   load_count
);

  ld_state_t         state, next_state;
  logic [ADDR_W-1:0] wr_ptr;
  logic              at_end;

`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [31:0] sum_q;
`endif

  // The pointer saturates at the last word; a transfer there ends the load.
  assign at_end = (wr_ptr == ADDR_W'(DEPTH - 1));

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) state <= LD_IDLE;
    else       state <= next_state;
  end

  // NOTE: every output and next_state gets a default before the case, so no
  // path through the block leaves a signal unassigned (no latches).
  always_comb begin
    next_state = state;
    load_ready = 1'b0;
    imem_we    = 1'b0;
    cpu_stall  = 1'b1;
    load_done  = 1'b0;
    imem_wdata = load_data;
    imem_addr  = {{(32 - ADDR_W - 2){1'b0}}, wr_ptr, 2'b00};

    case (state)
      LD_IDLE: begin
        cpu_stall = 1'b0;
        imem_addr = cpu_pc;
        if (load_start) next_state = LD_LOAD;
      end

      LD_LOAD: begin
        load_ready = 1'b1;
        imem_we    = load_valid;
        if (load_valid) begin
          if (load_last) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
            next_state = LD_CHECK;
`else
            next_state = LD_DONE;
`endif
          end else if (at_end) begin
            next_state = LD_IDLE;  // overflow: abandon without done
          end
        end
      end

      LD_DONE: begin
        load_done  = 1'b1;
        next_state = LD_IDLE;
      end

`ifdef IMEM_LOAD_CHECKSUM_EN
      LD_CHECK: begin
        // The checksum word is consumed here but never written to IMEM.
        load_ready = 1'b1;
        if (load_valid) next_state = (load_data == sum_q) ? LD_DONE : LD_IDLE;
      end
`endif

      default: next_state = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      load_count <= '0;
      load_err   <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      case (state)
        LD_IDLE: begin
          if (load_start) begin
            wr_ptr     <= '0;
            load_count <= '0;
            load_err   <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
            sum_q      <= '0;
`endif
          end
        end

        LD_LOAD: begin
          if (load_valid) begin
            load_count <= load_count + (ADDR_W + 1)'(1);
            if (!at_end) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (at_end && !load_last) load_err <= 1'b1;
`ifdef IMEM_LOAD_CHECKSUM_EN
            sum_q <= sum_q + load_data;
`endif
          end
        end

`ifdef IMEM_LOAD_CHECKSUM_EN
        LD_CHECK: begin
          if (load_valid && (load_data != sum_q)) load_err <= 1'b1;
        end
`endif

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// tb_imem_load_ctrl: self-checking bench for imem_load_ctrl.
// Expected IMEM writes are queued when a word is driven and popped by a
// negedge monitor whenever the DUT asserts imem_we. Idle passthrough runs from
// a vector table; loads, gaps, overflow and reset use hand-written sequences.
// Define IMEM_LOAD_CHECKSUM_EN for both bench and RTL to cover the checksum path.
module tb_imem_load_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic [31:0] cpu_pc;
  logic [31:0] imem_addr;
  logic        imem_we;
  logic [31:0] imem_wdata;
  logic        cpu_stall;
  logic        load_done;
  logic        load_err;
  logic [6:0]  load_count;

  imem_load_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .cpu_pc     (cpu_pc),
    .imem_addr  (imem_addr),
    .imem_we    (imem_we),
    .imem_wdata (imem_wdata),
    .cpu_stall  (cpu_stall),
    .load_done  (load_done),
    .load_err   (load_err),
    .load_count (load_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] exp_addr;
  } idle_vec_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  int          n_cmp = 0;
  int          n_err = 0;
  int          done_cnt = 0;
  int          ptr = 0;
  logic [31:0] sum_model = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every IMEM write must match the next queued write.
  always @(negedge clk) begin
    if (reset === 1'b0 && load_done === 1'b1) done_cnt++;
    if (reset === 1'b0 && imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected no write (t=%0t)",
                 imem_addr, imem_wdata, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", imem_addr, mon_e.addr);
        check("wr_data", imem_wdata, mon_e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    @(negedge clk);
    check("start_idle_stall", 32'(cpu_stall), 32'd0);
    step();
    load_start = 1'b0;
    ptr        = 0;
    sum_model  = '0;
  endtask

  task automatic send_word(input logic [31:0] data, input logic last);
    load_valid = 1'b1;
    load_data  = data;
    load_last  = last;
    exp_q.push_back('{addr: 32'(ptr * 4), data: data});
    sum_model += data;
    @(negedge clk);
    check("load_ready", 32'(load_ready), 32'd1);
    check("load_stall", 32'(cpu_stall), 32'd1);
    step();
    if (ptr < 63) ptr++;
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic gap(input int n);
    load_valid = 1'b0;
    repeat (n) begin
      @(negedge clk);
      check("gap_we", 32'(imem_we), 32'd0);
      check("gap_ready", 32'(load_ready), 32'd1);
      step();
    end
  endtask

  task automatic expect_done(input int count);
    @(negedge clk);
    check("done_pulse", 32'(load_done), 32'd1);
    check("done_stall", 32'(cpu_stall), 32'd1);
    check("done_ready", 32'(load_ready), 32'd0);
    check("done_we", 32'(imem_we), 32'd0);
    check("done_count", 32'(load_count), 32'(count));
    step();
    @(negedge clk);
    check("after_done_pulse", 32'(load_done), 32'd0);
    check("after_done_stall", 32'(cpu_stall), 32'd0);
    check("after_done_addr", imem_addr, cpu_pc);
    step();
  endtask

  // Completes a load after its last word (through CHECK when enabled).
  task automatic finish_load(input int count);
`ifdef IMEM_LOAD_CHECKSUM_EN
    load_valid = 1'b1;
    load_data  = sum_model;
    @(negedge clk);
    check("check_we", 32'(imem_we), 32'd0);
    check("check_ready", 32'(load_ready), 32'd1);
    step();
    load_valid = 1'b0;
`endif
    expect_done(count);
  endtask

  idle_vec_t   vecs[4];
  logic [31:0] words[3];
  int          d0;

  initial begin
    vecs[0] = '{pc: 32'h0000_001C, exp_addr: 32'h0000_001C};
    vecs[1] = '{pc: 32'h0000_0000, exp_addr: 32'h0000_0000};
    vecs[2] = '{pc: 32'hFFFF_FFFC, exp_addr: 32'hFFFF_FFFC};
    vecs[3] = '{pc: 32'h8000_0004, exp_addr: 32'h8000_0004};
    words[0] = 32'h0050_0113;
    words[1] = 32'h00C0_0193;
    words[2] = 32'hFF71_8393;

    reset = 1'b1; load_start = 1'b0; load_valid = 1'b0;
    load_last = 1'b0; load_data = '0; cpu_pc = 32'h0000_001C;
    repeat (2) step();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_ready", 32'(load_ready), 32'd0);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_err", 32'(load_err), 32'd0);
    check("rst_count", 32'(load_count), 32'd0);
    step();

    // Idle passthrough table
    for (int i = 0; i < 4; i++) begin
      cpu_pc = vecs[i].pc;
      @(negedge clk);
      check("idle_addr", imem_addr, vecs[i].exp_addr);
      check("idle_stall", 32'(cpu_stall), 32'd0);
      check("idle_ready", 32'(load_ready), 32'd0);
      check("idle_we", 32'(imem_we), 32'd0);
      step();
    end
    cpu_pc = 32'h0000_001C;

    // Basic back-to-back load
    d0 = done_cnt;
    start_load();
    for (int i = 0; i < 3; i++) send_word(words[i], i == 2);
    finish_load(3);
    check("basic_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("basic_sb_empty", 32'(exp_q.size()), 32'd0);

    // Gapped handshake
    d0 = done_cnt;
    start_load();
    for (int i = 0; i < 3; i++) begin
      send_word(words[i], i == 2);
      if (i < 2) gap(2);
    end
    finish_load(3);
    check("gap_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("gap_sb_empty", 32'(exp_q.size()), 32'd0);

    // Overflow: 64 words accepted, the 65th refused
    d0 = done_cnt;
    start_load();
    for (int i = 0; i < 64; i++) send_word(32'h1000_0000 + 32'(i), 1'b0);
    load_valid = 1'b1;
    load_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    check("ovf_ready", 32'(load_ready), 32'd0);
    check("ovf_we", 32'(imem_we), 32'd0);
    check("ovf_err", 32'(load_err), 32'd1);
    check("ovf_count", 32'(load_count), 32'd64);
    check("ovf_stall", 32'(cpu_stall), 32'd0);
    step();
    load_valid = 1'b0;
    check("ovf_no_done", 32'(done_cnt - d0), 32'd0);
    check("ovf_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset clears the sticky error
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_clears_err", 32'(load_err), 32'd0);
    check("rst_clears_count", 32'(load_count), 32'd0);
    step();

    // Reset mid-load after 2 of 5 words
    start_load();
    send_word(32'hA000_0001, 1'b0);
    send_word(32'hA000_0002, 1'b0);
    @(negedge clk);
    check("mid_count", 32'(load_count), 32'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_stall", 32'(cpu_stall), 32'd0);
    check("mid_rst_ready", 32'(load_ready), 32'd0);
    check("mid_rst_count", 32'(load_count), 32'd0);
    check("mid_rst_err", 32'(load_err), 32'd0);
    check("mid_rst_addr", imem_addr, cpu_pc);
    step();

    // Simultaneous reset and load_start: reset wins
    reset = 1'b1;
    load_start = 1'b1;
    step();
    reset = 1'b0;
    load_start = 1'b0;
    @(negedge clk);
    check("rst_vs_start_stall", 32'(cpu_stall), 32'd0);
    check("rst_vs_start_ready", 32'(load_ready), 32'd0);
    step();

`ifdef IMEM_LOAD_CHECKSUM_EN
    // Checksum match
    d0 = done_cnt;
    start_load();
    for (int i = 1; i <= 3; i++) send_word(32'(i), i == 3);
    load_valid = 1'b1;
    load_data  = 32'd6;
    @(negedge clk);
    check("cks_we", 32'(imem_we), 32'd0);
    check("cks_ready", 32'(load_ready), 32'd1);
    check("cks_stall", 32'(cpu_stall), 32'd1);
    step();
    load_valid = 1'b0;
    expect_done(3);
    check("cks_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("cks_err", 32'(load_err), 32'd0);

    // Checksum mismatch
    d0 = done_cnt;
    start_load();
    for (int i = 1; i <= 3; i++) send_word(32'(i), i == 3);
    load_valid = 1'b1;
    load_data  = 32'd7;
    @(negedge clk);
    check("cksbad_we", 32'(imem_we), 32'd0);
    step();
    load_valid = 1'b0;
    @(negedge clk);
    check("cksbad_done", 32'(load_done), 32'd0);
    check("cksbad_err", 32'(load_err), 32'd1);
    check("cksbad_stall", 32'(cpu_stall), 32'd0);
    step();
    check("cksbad_done_cnt", 32'(done_cnt - d0), 32'd0);
`endif

    check("final_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
